// File: rtl/paralelo_serial_tx.sv
// Parallel-to-serial lane transmitter: sends comma symbols after reset,
// then user bytes MSB first, with an idle symbol when no byte is pending.
module paralelo_serial_tx #(
  parameter logic [7:0]  COM_SYM    = 8'hBC,
  parameter logic [7:0]  IDLE_SYM   = 8'h7C,
  parameter int unsigned SYNC_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       data_out,
  output logic       active,
  output logic       sym_start
);

  localparam logic [3:0] SYNC_MAX = 4'(SYNC_COUNT);

  typedef enum logic [1:0] {
    ST_RST,
    ST_SYNC,
    ST_RUN
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] sync_cnt_q, sync_cnt_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  logic       active_q, active_d;

  logic boundary;
  logic accept;
  logic drain;

  assign boundary  = (bit_cnt_q == 3'd7);
  assign ready_out = (state_q == ST_RUN) &&
                     (!hold_full_q || boundary);
  assign accept    = valid_in && ready_out;
  assign data_out  = shift_q[7];
  assign active    = active_q;
  assign sym_start = (bit_cnt_q == 3'd0) &&
                     (state_q != ST_RST);

  // Register update; reset parks the lane on a symbol boundary.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state_q     <= ST_RST;
      shift_q     <= 8'h00;
      bit_cnt_q   <= 3'd7;
      sync_cnt_q  <= 4'd0;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      sync_cnt_q  <= sync_cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      active_q    <= active_d;
    end
  end

  // Next symbol selection on boundaries, shifting otherwise, and byte intake.
  always_comb begin
    state_d     = state_q;
    shift_d     = {shift_q[6:0], 1'b0};
    bit_cnt_d   = bit_cnt_q + 3'd1;
    sync_cnt_d  = sync_cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    active_d    = active_q;
    drain       = 1'b0;

    if (boundary) begin
      bit_cnt_d = 3'd0;
      unique case (state_q)
        ST_RST: begin
          shift_d = COM_SYM;
          if (SYNC_MAX == 4'd1) begin
            state_d  = ST_RUN;
            active_d = 1'b1;
          end else begin
            state_d    = ST_SYNC;
            sync_cnt_d = 4'd1;
          end
        end
        ST_SYNC: begin
          if (sync_cnt_q < SYNC_MAX) begin
            shift_d    = COM_SYM;
            sync_cnt_d = sync_cnt_q + 4'd1;
          end else begin
            state_d  = ST_RUN;
            active_d = 1'b1;
            drain    = 1'b1;
          end
        end
        ST_RUN: drain = 1'b1;
        default: state_d = ST_RST;
      endcase
    end

    if (drain) begin
      shift_d     = hold_full_q ? hold_q : IDLE_SYM;
      hold_full_d = 1'b0;
    end

    // A byte taken on the same edge that drains keeps the holding slot full.
    if (accept) begin
      hold_d      = data_in;
      hold_full_d = 1'b1;
    end
  end

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// Directed bench for paralelo_serial_tx: sync sequence, single byte,
// back-to-back bytes, early valid, reset mid-symbol, SYNC_COUNT=1 variant.
module tb_paralelo_serial_tx;

  logic       clk_32f;
  logic       reset;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_out, data_out, active, sym_start;
  logic       ready1, dout1, active1, sstart1;

  int checks = 0;
  int errors = 0;

  logic [7:0] s0, s1;
  int         r;

  paralelo_serial_tx dut (
    .clk_32f   (clk_32f),
    .reset     (reset),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .data_out  (data_out),
    .active    (active),
    .sym_start (sym_start)
  );

  paralelo_serial_tx #(.SYNC_COUNT(1)) dut1 (
    .clk_32f   (clk_32f),
    .reset     (reset),
    .data_in   (data_in),
    .valid_in  (1'b0),
    .ready_out (ready1),
    .data_out  (dout1),
    .active    (active1),
    .sym_start (sstart1)
  );

  initial clk_32f = 1'b0;
  always #5 clk_32f = ~clk_32f;

  task automatic tick();
    @(posedge clk_32f);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Collect one symbol from both lanes, counting cycles with ready_out high.
  task automatic get_sym(output logic [7:0] a,
                         output logic [7:0] b,
                         output int rdy);
    a = 8'h00;
    b = 8'h00;
    rdy = 0;
    for (int i = 0; i < 8; i++) begin
      a = {a[6:0], data_out};
      b = {b[6:0], dout1};
      if (ready_out) rdy++;
      tick();
    end
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (!sym_start && n < 16) begin
      tick();
      n++;
    end
    check(tag, 32'(sym_start), 32'd1);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!ready_out && n < 16) begin
      tick();
      n++;
    end
    check(tag, 32'(ready_out), 32'd1);
  endtask

  initial begin
    reset    = 1'b1;
    valid_in = 1'b0;
    data_in  = 8'h00;
    tick();
    tick();
    check("rst_dout", 32'(data_out), 0);
    check("rst_ready", 32'(ready_out), 0);
    check("rst_active", 32'(active), 0);
    check("rst_symstart", 32'(sym_start), 0);
    check("rst_dout1", 32'(dout1), 0);

    // Sync sequence after release.
    reset = 1'b0;
    tick();
    check("sync_symstart", 32'(sym_start), 1);
    check("sync_ready", 32'(ready_out), 0);
    for (int i = 0; i < 4; i++) begin
      get_sym(s0, s1, r);
      check("sync_bc", 32'(s0), 32'hBC);
      check("sync_rdy", 32'(r), 0);
      if (i == 0) begin
        check("sc1_bc", 32'(s1), 32'hBC);
        check("sc1_active", 32'(active1), 1);
        check("sc1_symstart", 32'(sstart1), 1);
        check("active_early", 32'(active), 0);
      end
      if (i == 1) check("sc1_idle", 32'(s1), 32'h7C);
      if (i == 2) check("active_pre", 32'(active), 0);
    end
    check("active_rise", 32'(active), 1);
    check("active_symstart", 32'(sym_start), 1);
    get_sym(s0, s1, r);
    check("run_idle", 32'(s0), 32'h7C);

    // Single byte offered mid idle symbol.
    tick();
    tick();
    tick();
    data_in  = 8'hA5;
    valid_in = 1'b1;
    check("a5_ready", 32'(ready_out), 1);
    tick();
    valid_in = 1'b0;
    check("a5_full_ready", 32'(ready_out), 0);
    wait_start("a5_wait");
    get_sym(s0, s1, r);
    check("a5_sym", 32'(s0), 32'hA5);
    get_sym(s0, s1, r);
    check("a5_after", 32'(s0), 32'h7C);

    // Back-to-back bytes.
    data_in  = 8'h01;
    valid_in = 1'b1;
    check("b2b_ready0", 32'(ready_out), 1);
    tick();
    data_in = 8'h02;
    check("b2b_busy", 32'(ready_out), 0);
    wait_ready("b2b_wait");
    tick();
    data_in = 8'h03;
    check("b2b_start", 32'(sym_start), 1);
    get_sym(s0, s1, r);
    valid_in = 1'b0;
    check("b2b_01", 32'(s0), 32'h01);
    check("b2b_pulse", 32'(r), 1);
    get_sym(s0, s1, r);
    check("b2b_02", 32'(s0), 32'h02);
    get_sym(s0, s1, r);
    check("b2b_03", 32'(s0), 32'h03);
    get_sym(s0, s1, r);
    check("b2b_idle", 32'(s0), 32'h7C);

    // Reset mid-shift of 3C with a pending byte.
    data_in  = 8'h3C;
    valid_in = 1'b1;
    tick();
    data_in = 8'h55;
    wait_start("rst3c_wait");
    valid_in = 1'b0;
    tick();
    tick();
    tick();
    check("rst3c_bit4", 32'(data_out), 1);
    reset = 1'b1;
    tick();
    check("rst3c_dout", 32'(data_out), 0);
    check("rst3c_ready", 32'(ready_out), 0);
    check("rst3c_active", 32'(active), 0);
    check("rst3c_symstart", 32'(sym_start), 0);
    reset = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      get_sym(s0, s1, r);
      check("rst3c_bc", 32'(s0), 32'hBC);
    end
    get_sym(s0, s1, r);
    check("rst3c_lost", 32'(s0), 32'h7C);

    // Byte offered during SYNC is held off until RUN.
    reset = 1'b1;
    tick();
    reset    = 1'b0;
    data_in  = 8'hFF;
    valid_in = 1'b1;
    tick();
    check("ff_sync_ready", 32'(ready_out), 0);
    for (int i = 0; i < 4; i++) begin
      get_sym(s0, s1, r);
      check("ff_sync_bc", 32'(s0), 32'hBC);
      check("ff_sync_rdy", 32'(r), 0);
    end
    check("ff_run_ready", 32'(ready_out), 1);
    check("ff_idle_bit7", 32'(data_out), 0);
    check("ff_active", 32'(active), 1);
    tick();
    valid_in = 1'b0;
    wait_start("ff_wait");
    get_sym(s0, s1, r);
    check("ff_sym", 32'(s0), 32'hFF);
    get_sym(s0, s1, r);
    check("ff_after", 32'(s0), 32'h7C);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
